dram_ctrl_q: RTL

DRAM_CTRL_Q -- requirements
Module: dram_ctrl_q

---
 rtl/dram_pkg.sv | 17 +
 rtl/dram_req_fifo.sv | 44 ++++
 rtl/dram_ctrl_q.sv | 97 +++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the queued DRAM controller
//   req_t        : request queue entry at the default controller widths
//   state_t      : engine states IDLE / BUSY / RESP
//   DRAM_TIMER_W : service timer width
package dram_pkg;
    localparam int DRAM_TIMER_W = 8;
    localparam int DRAM_ADDR_W  = 40;
    localparam int DRAM_DATA_W  = 64;
    localparam int DRAM_TAG_W   = 4;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef struct packed {
        logic [DRAM_ADDR_W-1:0] addr;
        logic                   write;
        logic [DRAM_DATA_W-1:0] wdata;
        logic [DRAM_TAG_W-1:0]  tag;
    } req_t;
endpackage

// File: rtl/dram_req_fifo.sv
// dram_req_fifo: synchronous FIFO of request entries
//   clk, rst_n  : clock, async active-low reset (clears pointers and count)
//   push, din   : write an entry when not full
//   pop, dout   : drop the head entry when not empty; dout shows the head
//   full, empty : occupancy flags from registered count
module dram_req_fifo
    import dram_pkg::*;
#(
    parameter type T     = req_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    T mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic do_push, do_pop;
    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/dram_ctrl_q.sv
// dram_ctrl_q: queued single-engine DRAM model with fixed read/write service latency
//   clk, rst_n                                  : clock, async active-low reset
//   req_valid/req_ready, req_addr/write/wdata/tag : request handshake and payload
//   resp_valid/resp_ready, resp_rdata/tag/write   : in-order response handshake
//   busy                                        : queue non-empty or engine active
module dram_ctrl_q
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4,
    parameter int QDEPTH     = 4,
    parameter int RD_LATENCY = 50,
    parameter int WR_LATENCY = 20,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_write,
    output logic                  busy
);
    localparam int OFS = $clog2(DATA_WIDTH / 8);
    localparam int IW  = $clog2(MEM_WORDS);
    localparam logic [DRAM_TIMER_W-1:0] RD_T = DRAM_TIMER_W'(RD_LATENCY - 1);
    localparam logic [DRAM_TIMER_W-1:0] WR_T = DRAM_TIMER_W'(WR_LATENCY - 1);
    // Same layout as req_t, sized by this instance's parameters
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;
    entry_t in_req, head, cur;
    state_t state, state_n;
    logic [DRAM_TIMER_W-1:0] timer;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [IW-1:0] idx;
    logic full, empty, pop, done;
    assign in_req = '{addr: req_addr, write: req_write, wdata: req_wdata, tag: req_tag};
    dram_req_fifo #(.T(entry_t), .DEPTH(QDEPTH)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (req_valid),
        .din  (in_req),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    assign req_ready  = !full;
    assign resp_valid = state == RESP;
    assign busy       = !empty || state != IDLE;
    assign idx        = cur.addr[OFS +: IW];
    // The access happens on the edge that leaves BUSY with the timer at zero
    assign done       = state == BUSY && timer == '0;
    always_comb begin
        pop     = state == IDLE && !empty;
        state_n = state == IDLE ? (empty ? IDLE : BUSY) :
                  state == BUSY ? (done ? RESP : BUSY) :
                  (resp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            cur        <= '0;
            resp_rdata <= '0;
            resp_tag   <= '0;
            resp_write <= 1'b0;
        end else begin
            state <= state_n;
            if (pop) begin
                cur   <= head;
                timer <= head.write ? WR_T : RD_T;
            end else if (state == BUSY && timer != '0) begin
                timer <= timer - 1'b1;
            end
            if (done) begin
                resp_rdata <= cur.write ? '0 : mem[idx];
                resp_tag   <= cur.tag;
                resp_write <= cur.write;
            end
        end
    // Backing store has no reset; contents survive rst_n
    always_ff @(posedge clk)
        if (done && cur.write) mem[idx] <= cur.wdata;
endmodule
